// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and helpers.
package aes_pkg;

   localparam int AES_NR = 10;
   localparam int AES_KW = 128;

   // Starting round constant for round 1.
   localparam logic [7:0] AES_RC_START = 8'h01;

   // Round-key register file, round 0 (cipher key) through round AES_NR.
   typedef logic [AES_KW-1:0] aes_rk_t [0:AES_NR];

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      READY  = 2'd2
   } aes_state_t;

   // GF(2^8) doubling modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/key_expansion.sv
// One AES-128 key-expansion round: derives round key i from round key i-1.
module key_expansion
   import aes_pkg::*;
(
   input  logic [AES_KW-1:0] prev_key,
   input  logic [7:0]        rc,
   output logic [AES_KW-1:0] next_key
);

   // Forward S-box, entry 0x00 in the top byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      sbox = SBOX[(11'd2040 - {b, 3'b000}) +: 8];
   endfunction

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot, sub, temp;
   logic [31:0] n0, n1, n2, n3;

   // RotWord, SubWord, Rcon, then the running XOR chain across the four words.
   always_comb begin
      w0   = prev_key[127:96];
      w1   = prev_key[95:64];
      w2   = prev_key[63:32];
      w3   = prev_key[31:0];
      rot  = {w3[23:0], w3[31:24]};
      sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      temp = sub ^ {rc, 24'h000000};
      n0   = w0 ^ temp;
      n1   = w1 ^ n0;
      n2   = w2 ^ n1;
      n3   = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 round-key sequencer: expands one round per cycle into an 11-entry
// register file and serves round keys through a combinational read port.
// Handshake: a key transfers on a rising edge where key_valid && key_ready
// && !flush; key_ready is low only while an expansion is running.
module aes_key_sched_ctrl
   import aes_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_valid,
   input  logic [AES_KW-1:0] key_in,
   output logic              key_ready,
   input  logic              flush,
   input  logic [3:0]        rk_idx,
   output logic [AES_KW-1:0] rk_out,
   output logic              keys_valid,
   output logic              done,
   output logic              busy
);

   aes_state_t        state;
   logic [3:0]        cnt;
   logic [7:0]        rc;
   logic [AES_KW-1:0] prev_key;
   logic [AES_KW-1:0] next_key;
   aes_rk_t           rk;
   logic              accept;

   assign key_ready = (state != EXPAND);
   assign busy      = (state == EXPAND);
   assign accept    = key_valid && key_ready && !flush;

   // prev_key mirrors rk[cnt-1] so the round function never sees a wide mux.
   key_expansion u_key_expansion (
      .prev_key (prev_key),
      .rc       (rc),
      .next_key (next_key)
   );

   // Controller FSM, round counter, Rcon xtime register and key storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         rc         <= AES_RC_START;
         prev_key   <= '0;
         keys_valid <= 1'b0;
         done       <= 1'b0;
         for (int i = 0; i <= AES_NR; i++) rk[i] <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            // Stored keys are kept; only the control state is abandoned.
            state      <= IDLE;
            cnt        <= 4'd0;
            keys_valid <= 1'b0;
         end else if (accept) begin
            rk[0]      <= key_in;
            prev_key   <= key_in;
            rc         <= AES_RC_START;
            cnt        <= 4'd1;
            keys_valid <= 1'b0;
            state      <= EXPAND;
         end else if (state == EXPAND) begin
            rk[cnt]  <= next_key;
            prev_key <= next_key;
            rc       <= xtime(rc);
            if (cnt == 4'(AES_NR)) begin
               state      <= READY;
               cnt        <= 4'd0;
               keys_valid <= 1'b1;
               done       <= 1'b1;
            end else begin
               cnt <= cnt + 4'd1;
            end
         end
      end
   end

   // Indices beyond the last round read as zero.
   always_comb begin
      rk_out = '0;
      if (rk_idx <= 4'(AES_NR)) rk_out = rk[rk_idx];
   end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for the AES-128 round-key sequencer using FIPS-197 vectors.
module tb_aes_key_sched_ctrl;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_KEY = 128'h0;
   localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic         clk;
   logic         rst_n;
   logic         key_valid;
   logic [127:0] key_in;
   logic         key_ready;
   logic         flush;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;
   logic         keys_valid;
   logic         done;
   logic         busy;

   int total;
   int bad;

   aes_key_sched_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key_in     (key_in),
      .key_ready  (key_ready),
      .flush      (flush),
      .rk_idx     (rk_idx),
      .rk_out     (rk_out),
      .keys_valid (keys_valid),
      .done       (done),
      .busy       (busy)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Offer a key for one edge; returns at the falling edge just after it.
   task automatic apply_key(input logic [127:0] k);
      @(negedge clk);
      key_valid = 1'b1;
      key_in    = k;
      @(negedge clk);
      key_valid = 1'b0;
      key_in    = $urandom_range(0, 255);
   endtask

   // Counts edges from start until done, plus busy cycles and done pulses seen
   // (including a short tail after done). Budget-limited.
   task automatic wait_done(input int start, output int done_cyc, output int busy_cnt,
                            output int done_cnt);
      int cyc;
      cyc      = start;
      busy_cnt = busy ? 1 : 0;
      done_cnt = 0;
      done_cyc = -1;
      while (done_cyc < 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
      if (done_cyc < 0) check_eq("done_timeout", 128'(cyc), 128'd10);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
   endtask

   task automatic read_rk(input logic [3:0] idx, input string tag, input logic [127:0] exp);
      rk_idx = idx;
      #1;
      check_eq(tag, rk_out, exp);
   endtask

   initial begin
      int dc, bc, nc;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_in    = '0;
      flush     = 1'b0;
      rk_idx    = 4'd0;

      // Reset state
      #12;
      check_eq("rst_busy", 128'(busy), 128'd0);
      check_eq("rst_done", 128'(done), 128'd0);
      check_eq("rst_kv", 128'(keys_valid), 128'd0);
      check_eq("rst_ready", 128'(key_ready), 128'd1);
      read_rk(4'd0, "rst_rk0", 128'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // FIPS key: latency, busy length, single done
      apply_key(FIPS_KEY);
      check_eq("fips_busy", 128'(busy), 128'd1);
      check_eq("fips_ready", 128'(key_ready), 128'd0);
      wait_done(0, dc, bc, nc);
      check_eq("fips_latency", 128'(dc), 128'd10);
      check_eq("fips_busy_cycles", 128'(bc), 128'd10);
      check_eq("fips_done_count", 128'(nc), 128'd1);
      check_eq("fips_kv", 128'(keys_valid), 128'd1);
      read_rk(4'd0, "fips_rk0", FIPS_KEY);
      read_rk(4'd1, "fips_rk1", FIPS_RK1);
      read_rk(4'd10, "fips_rk10", FIPS_RK10);

      // All-zero key from READY: keys_valid drops at accept, out-of-range read
      apply_key(ZERO_KEY);
      check_eq("zero_kv_drop", 128'(keys_valid), 128'd0);
      wait_done(0, dc, bc, nc);
      check_eq("zero_latency", 128'(dc), 128'd10);
      check_eq("zero_kv", 128'(keys_valid), 128'd1);
      read_rk(4'd1, "zero_rk1", ZERO_RK1);
      read_rk(4'd10, "zero_rk10", ZERO_RK10);
      read_rk(4'd12, "idx12", 128'h0);
      read_rk(4'd15, "idx15", 128'h0);

      // key_valid during EXPAND is ignored
      apply_key(FIPS_KEY);
      repeat (3) @(negedge clk);
      key_valid = 1'b1;
      key_in    = ZERO_KEY;
      check_eq("exp_ready_low", 128'(key_ready), 128'd0);
      @(negedge clk);
      key_valid = 1'b0;
      wait_done(4, dc, bc, nc);
      check_eq("ign_latency", 128'(dc), 128'd10);
      read_rk(4'd0, "ign_rk0", FIPS_KEY);
      read_rk(4'd10, "ign_rk10", FIPS_RK10);

      // flush mid-expansion, then re-expand
      apply_key(ZERO_KEY);
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_eq("flush_busy", 128'(busy), 128'd0);
      check_eq("flush_ready", 128'(key_ready), 128'd1);
      check_eq("flush_kv", 128'(keys_valid), 128'd0);
      nc = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || keys_valid) nc++;
      end
      check_eq("flush_no_done", 128'(nc), 128'd0);
      read_rk(4'd0, "flush_rk0", ZERO_KEY);
      apply_key(FIPS_KEY);
      wait_done(0, dc, bc, nc);
      check_eq("reexp_latency", 128'(dc), 128'd10);
      read_rk(4'd1, "reexp_rk1", FIPS_RK1);
      read_rk(4'd10, "reexp_rk10", FIPS_RK10);

      // flush together with key_valid in READY: no accept
      @(negedge clk);
      flush     = 1'b1;
      key_valid = 1'b1;
      key_in    = ZERO_KEY;
      @(negedge clk);
      flush     = 1'b0;
      key_valid = 1'b0;
      check_eq("fv_ready", 128'(key_ready), 128'd1);
      check_eq("fv_busy", 128'(busy), 128'd0);
      check_eq("fv_kv", 128'(keys_valid), 128'd0);
      read_rk(4'd0, "fv_rk0", FIPS_KEY);

      // Asynchronous reset in the middle of an expansion
      apply_key(ZERO_KEY);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_busy", 128'(busy), 128'd0);
      check_eq("arst_done", 128'(done), 128'd0);
      check_eq("arst_kv", 128'(keys_valid), 128'd0);
      check_eq("arst_ready", 128'(key_ready), 128'd1);
      nc = 0;
      for (int i = 0; i <= 10; i++) begin
         rk_idx = 4'(i);
         #1;
         if (rk_out !== 128'h0) nc++;
      end
      check_eq("arst_rk_nonzero", 128'(nc), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
